// File: rtl/uart_pw_lock.sv
// rtl/uart_pw_lock.sv - password lock fed by a UART byte stream
// Checks the entry on the fly, grants access on a correct entry and locks out after repeated failures.
module uart_pw_lock #(
  parameter int          PW_LEN      = 4,
  parameter logic [63:0] PW          = 64'h0000_0000_3132_3334,
  parameter logic [7:0]  TERM        = 8'h0D,
  parameter logic [7:0]  CLR         = 8'h1B,
  parameter int          MAX_FAIL    = 3,
  parameter int          LOCK_CYCLES = 100_000_000
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       unlock,
  output logic       fail,
  output logic       locked,
  output logic [3:0] char_count,
  output logic [1:0] fail_count
);

  localparam int CW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    ENTRY,
    GRANTED,
    LOCKOUT
  } state_t;

  state_t        state;
  logic          mismatch;
  logic [CW-1:0] lock_cnt;
  logic [7:0]    exp_byte;
  logic [1:0]    fail_next;

  // Expected character at the current position; first character sits in the top byte.
  always_comb begin
    exp_byte = 8'h00;
    for (int i = 0; i < PW_LEN; i++) begin
      if (char_count == 4'(i)) begin
        exp_byte = PW[8*(PW_LEN-i)-1 -: 8];
      end
    end
  end

  assign fail_next = fail_count + 2'd1;

  always_ff @(posedge clkin) begin
    if (rst) begin
      state      <= ENTRY;
      unlock     <= 1'b0;
      fail       <= 1'b0;
      locked     <= 1'b0;
      char_count <= 4'd0;
      fail_count <= 2'd0;
      mismatch   <= 1'b0;
      lock_cnt   <= '0;
    end else begin
      fail <= 1'b0;
      case (state)
        ENTRY: begin
          if (rx_valid) begin
            if (rx_byte == TERM) begin
              char_count <= 4'd0;
              mismatch   <= 1'b0;
              if (char_count == 4'(PW_LEN) && !mismatch) begin
                unlock     <= 1'b1;
                fail_count <= 2'd0;
                state      <= GRANTED;
              end else begin
                fail       <= 1'b1;
                fail_count <= fail_next;
                if (fail_next == 2'(MAX_FAIL)) begin
                  locked   <= 1'b1;
                  lock_cnt <= CW'(LOCK_CYCLES - 1);
                  state    <= LOCKOUT;
                end
              end
            end else if (rx_byte == CLR) begin
              char_count <= 4'd0;
              mismatch   <= 1'b0;
            end else begin
              if (char_count != 4'd15) begin
                char_count <= char_count + 4'd1;
              end
              if (char_count >= 4'(PW_LEN) || rx_byte != exp_byte) begin
                mismatch <= 1'b1;
              end
            end
          end
        end
        GRANTED: begin
          if (rx_valid && rx_byte == CLR) begin
            unlock <= 1'b0;
            state  <= ENTRY;
          end
        end
        LOCKOUT: begin
          // Counter was loaded with LOCK_CYCLES-1 on the locking edge, so locked spans LOCK_CYCLES cycles.
          if (lock_cnt == '0) begin
            locked     <= 1'b0;
            fail_count <= 2'd0;
            state      <= ENTRY;
          end else begin
            lock_cnt <= lock_cnt - CW'(1);
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pw_lock.sv
// tb/tb_uart_pw_lock.sv - directed bench for uart_pw_lock
// Bytes are driven at the falling edge and outputs sampled at the following falling edge.
module tb_uart_pw_lock;

  logic       clkin = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       unlock;
  logic       fail;
  logic       locked;
  logic [3:0] char_count;
  logic [1:0] fail_count;

  int n_checks = 0;
  int n_pass = 0;
  int lk_cycles = 0;

  uart_pw_lock #(
    .PW_LEN(4),
    .PW(64'h0000_0000_3132_3334),
    .TERM(8'h0D),
    .CLR(8'h1B),
    .MAX_FAIL(3),
    .LOCK_CYCLES(20)
  ) dut (
    .clkin(clkin),
    .rst(rst),
    .rx_valid(rx_valid),
    .rx_byte(rx_byte),
    .unlock(unlock),
    .fail(fail),
    .locked(locked),
    .char_count(char_count),
    .fail_count(fail_count)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clkin);
    if (locked) lk_cycles++;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_good();
    send(8'h31); send(8'h32); send(8'h33); send(8'h34); send(8'h0D);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_unlock"}, 32'(unlock), 0);
    check({tag, "_fail"}, 32'(fail), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_cc"}, 32'(char_count), 0);
    check({tag, "_fc"}, 32'(fail_count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clkin);
    rst = 1'b0;
    check_all_zero("reset");

    // Correct entry
    send(8'h31); send(8'h32); send(8'h33); send(8'h34);
    check("good_cc4", 32'(char_count), 4);
    send(8'h0D);
    check("good_unlock", 32'(unlock), 1);
    check("good_fc", 32'(fail_count), 0);
    check("good_cc", 32'(char_count), 0);
    check("good_nofail", 32'(fail), 0);
    step();
    check("granted_hold", 32'(unlock), 1);
    send(8'h41);
    check("granted_ignore41", 32'(unlock), 1);
    send(8'h1B);
    check("relock", 32'(unlock), 0);

    // Saturation and clear
    for (int i = 0; i < 16; i++) send(8'h41);
    check("sat_cc15", 32'(char_count), 15);
    send(8'h1B);
    check("sat_clr_cc", 32'(char_count), 0);
    send(8'h31); send(8'h1B);
    check("clr_cc", 32'(char_count), 0);
    check("clr_nofail", 32'(fail), 0);
    send_good();
    check("clr_then_good_unlock", 32'(unlock), 1);
    check("clr_then_good_fc", 32'(fail_count), 0);
    send(8'h1B);

    // Wrong and short entries
    send(8'h31); send(8'h32); send(8'h33); send(8'h35); send(8'h0D);
    check("wrong_fail", 32'(fail), 1);
    check("wrong_fc", 32'(fail_count), 1);
    check("wrong_unlock", 32'(unlock), 0);
    step();
    check("wrong_fail_1cyc", 32'(fail), 0);
    send(8'h31); send(8'h32); send(8'h33); send(8'h0D);
    check("short_fail", 32'(fail), 1);
    check("short_fc", 32'(fail_count), 2);
    check("short_locked", 32'(locked), 0);
    send(8'h1B);
    check("clr_keeps_fc", 32'(fail_count), 2);
    check("clr_no_pulse", 32'(fail), 0);

    // Over-length third failure triggers lockout
    send(8'h31); send(8'h32); send(8'h33); send(8'h34); send(8'h34);
    check("over_cc5", 32'(char_count), 5);
    lk_cycles = 0;
    send(8'h0D);
    check("over_fail", 32'(fail), 1);
    check("lock_with_fail", 32'(locked), 1);
    check("lock_fc", 32'(fail_count), 3);
    send_good();
    check("lockout_ignore_unlock", 32'(unlock), 0);
    check("lockout_ignore_cc", 32'(char_count), 0);
    check("lockout_still_locked", 32'(locked), 1);
    for (int i = 0; i < 60 && locked; i++) step();
    check("lock_released", 32'(locked), 0);
    check("lock_duration", 32'(lk_cycles), 20);
    check("lock_fc_clear", 32'(fail_count), 0);
    send_good();
    check("post_lock_unlock", 32'(unlock), 1);

    // Reset in GRANTED, with a byte presented at the same edge
    rst = 1'b1; rx_valid = 1'b1; rx_byte = 8'h31;
    step();
    rst = 1'b0; rx_valid = 1'b0;
    check_all_zero("rst_granted");

    // Reset mid-entry
    send(8'h31); send(8'h32);
    check("mid_cc2", 32'(char_count), 2);
    rst = 1'b1; step(); rst = 1'b0;
    check_all_zero("rst_mid");

    // Reset in LOCKOUT: bare terminators count as failures
    send(8'h0D); send(8'h0D); send(8'h0D);
    check("bare_term_lock", 32'(locked), 1);
    rst = 1'b1; step(); rst = 1'b0;
    check_all_zero("rst_lockout");
    send_good();
    check("after_rst_unlock", 32'(unlock), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_pw_lock.md
UART_PW_LOCK -- requirements
Module: uart_pw_lock

Interface
REQ-001 Parameter PW_LEN, default 4, number of password characters (1..8).
REQ-002 Parameter PW, default 64'h0000_0000_3132_3334, expected password bytes, first character in bits [8*PW_LEN-1 -: 8] and last character in bits [7:0].
REQ-003 Parameter TERM, default 8'h0D, terminator byte that submits an entry.
REQ-004 Parameter CLR, default 8'h1B, clear byte that aborts the entry or relocks.
REQ-005 Parameter MAX_FAIL, default 3, number of consecutive failures that triggers lockout (1..3).
REQ-006 Parameter LOCK_CYCLES, default 100_000_000, length of lockout in clkin cycles.
REQ-007 Port clkin, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-008 Port rst, input, 1 bit, synchronous active-high reset.
REQ-009 Port rx_valid, input, 1 bit, one-cycle strobe marking that rx_byte holds a new received byte.
REQ-010 Port rx_byte, input, 8 bits, received byte; sampled only when rx_valid=1.
REQ-011 Port unlock, output, 1 bit, level that is high while access is granted.
REQ-012 Port fail, output, 1 bit, one-cycle pulse for each rejected entry.
REQ-013 Port locked, output, 1 bit, level that is high during lockout.
REQ-014 Port char_count, output, 4 bits, number of characters in the current entry; saturates at 15.
REQ-015 Port fail_count, output, 2 bits, number of consecutive failed entries.

Function
REQ-016 The FSM SHALL have the states ENTRY, GRANTED and LOCKOUT; all outputs are registered.
REQ-017 In ENTRY, a byte that is neither TERM nor CLR SHALL increment char_count, saturating at 15.
- If char_count >= PW_LEN, or the byte does not equal the PW byte at index char_count, the block SHALL set the internal mismatch flag.
REQ-018 The block SHALL NOT store the entry; comparison is on the fly using char_count as the index.
REQ-019 A TERM byte in ENTRY with char_count==PW_LEN and mismatch=0 SHALL cause the following:
- unlock goes high on the next cycle.
- The next state is GRANTED.
- fail_count clears to 0.
- char_count and mismatch clear.
REQ-020 Any other TERM byte in ENTRY, including TERM with char_count=0, SHALL cause the following:
- fail pulses high for exactly the next cycle.
- fail_count increments.
- char_count and mismatch clear.
REQ-021 When that increment reaches MAX_FAIL, the block SHALL do the following:
- locked rises in the same cycle as the fail pulse.
- The state becomes LOCKOUT.
- The lockout counter loads LOCK_CYCLES-1.
REQ-022 A CLR byte in ENTRY SHALL clear char_count and mismatch; fail_count is unchanged and no fail pulse is produced.
REQ-023 In GRANTED, unlock SHALL hold at 1.
- A CLR byte SHALL drop unlock on the next cycle and return the state to ENTRY.
- All other bytes SHALL be ignored.
REQ-024 In LOCKOUT, all rx_valid strobes SHALL be ignored and the counter SHALL decrement once per cycle.
REQ-025 When the lockout counter reaches 0, the block SHALL do the following on the next cycle:
- locked clears.
- fail_count clears.
- The state becomes ENTRY.
REQ-026 The total locked-high duration SHALL be exactly LOCK_CYCLES cycles.
REQ-027 The lockout counter width SHALL be $clog2(LOCK_CYCLES+1) bits.
REQ-028 Bytes arriving on consecutive cycles (rx_valid high back-to-back) SHALL each be processed; no byte is dropped outside LOCKOUT.
REQ-029 Latency from an accepted rx_valid to any output update SHALL be exactly 1 cycle.

Reset
REQ-030 When rst=1 at a clock edge, the block SHALL do the following:
- Set the state to ENTRY.
- Drive unlock=0, fail=0, locked=0, char_count=0 and fail_count=0.
- Clear mismatch and the lockout counter.
REQ-031 Reset SHALL take priority over rx_valid in the same cycle and SHALL abort GRANTED or LOCKOUT immediately.

Verification
REQ-032 Correct entry: bytes 31,32,33,34,0D with defaults -> unlock=1 one cycle after 0D, fail_count=0, char_count=0.
REQ-033 Wrong and short entries:
- 31,32,33,35,0D -> single-cycle fail pulse, fail_count=1.
- 31,32,33,0D -> fail pulse, fail_count=2.
REQ-034 Over-length and clear:
- 31,32,33,34,34,0D -> fail pulse, char_count=5 before 0D.
- 31,1B,31,32,33,34,0D -> unlock=1 with fail_count unchanged.
REQ-035 Lockout: three wrong entries with LOCK_CYCLES=20 cause the following:
- locked rises together with the third fail pulse.
- A correct entry sent during lockout is ignored.
- locked is high for exactly 20 cycles, then fail_count=0.
- A correct entry afterwards unlocks.
REQ-036 Relock and reset:
- In GRANTED, 41 is ignored, and 1B drops unlock on the next cycle.
- rst asserted mid-entry, in GRANTED, or in LOCKOUT returns all outputs to 0 on the next edge.
